// File: rtl/bnn_weight_streamer_pkg.sv
// Shared constants and helpers for the BNN weight streamer.
package bnn_stream_pkg;
   localparam int NUM_CH_DEF = 10;
   localparam int WORD_W_DEF = 32;
   localparam int DEPTH_DEF  = 4;
   localparam int CONV_LANE  = NUM_CH_DEF;

   function automatic int lane_w(input int num_ch);
      return $clog2(num_ch + 1);
   endfunction
endpackage

// File: rtl/bnn_weight_streamer_if.sv
// Host word-write port: request, target lane, data and per-lane ready.
interface bnn_weight_streamer_if
   import bnn_stream_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int WORD_W = WORD_W_DEF
);
   localparam int LANE_W = lane_w(NUM_CH);

   logic              wr_valid;
   logic              wr_ready;
   logic [LANE_W-1:0] wr_lane;
   logic [WORD_W-1:0] wr_data;

   modport master (output wr_valid, output wr_lane, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_lane, input wr_data, output wr_ready);
endinterface

// File: rtl/bnn_lane_serialiser.sv
// One weight lane: word FIFO feeding a down-counting LSB-first bit serialiser.
module bnn_lane_serialiser #(
   parameter int WORD_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              push,
   input  logic [WORD_W-1:0] push_data,
   input  logic              consume,
   input  logic              clr_err,
   output logic              full,
   output logic              bit_out,
   output logic              empty,
   output logic              underrun
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(WORD_W + 1);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW:0]       rd_ptr;
   logic [AW:0]       wr_ptr;
   logic [WORD_W-1:0] sh;
   logic [CW-1:0]     cnt;
   logic              fifo_empty;
   logic              do_push;
   logic              reload;
   logic              starved;

   assign fifo_empty = (rd_ptr == wr_ptr);
   assign full       = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
   assign do_push    = push && !full;
   assign starved    = (cnt == '0);
   assign reload     = !fifo_empty && (starved || (cnt == CW'(1) && consume));

   // sh is zero whenever cnt is zero, so sh[0] is directly the lane output.
   assign bit_out = sh[0];
   assign empty   = fifo_empty && starved;

   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         sh       <= '0;
         cnt      <= '0;
         underrun <= 1'b0;
      end else if (flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         sh       <= '0;
         cnt      <= '0;
         underrun <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (reload) begin
            rd_ptr <= rd_ptr + 1'b1;
            sh     <= mem[rd_ptr[AW-1:0]];
            cnt    <= CW'(WORD_W);
         end else if (consume && !starved) begin
            sh  <= sh >> 1;
            cnt <= cnt - CW'(1);
         end
         if (consume && starved)
            underrun <= 1'b1;
         else if (clr_err)
            underrun <= 1'b0;
      end
   end
endmodule

// File: rtl/bnn_weight_streamer.sv
// BNN weight streamer: host word writes fan out to NUM_CH FC lanes plus one conv lane.
// Optional pixel binariser enabled by defining BNN_IMG_BIN_EN.
module bnn_weight_streamer
   import bnn_stream_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int WORD_W = WORD_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 flush,
   bnn_weight_streamer_if.slave wr,
   input  logic                 fc_ivalid,
   input  logic                 weight_en_0,
   input  logic                 weight_en_1,
   output logic [NUM_CH-1:0]    fc_weight,
   output logic                 conv_weight,
   output logic [NUM_CH:0]      lane_empty,
   output logic [NUM_CH:0]      underrun,
   input  logic                 clr_err
`ifdef BNN_IMG_BIN_EN
   ,
   input  logic                 pix_valid,
   input  logic [7:0]           pix_data,
   output logic                 image_bit
`endif
);
   localparam int LANE_W = lane_w(NUM_CH);
   localparam int NL     = NUM_CH + 1;

   logic [NL-1:0] lane_full;
   logic [NL-1:0] lane_push;
   logic [NL-1:0] lane_consume;
   logic [NL-1:0] lane_bit;
   logic          lane_in_range;
   logic          wr_accept;

   assign lane_in_range = (wr.wr_lane <= LANE_W'(NUM_CH));

   // Out-of-range lanes always look ready so the host write is swallowed.
   always_comb begin
      wr.wr_ready = 1'b1;
      if (lane_in_range)
         wr.wr_ready = ~lane_full[wr.wr_lane];
   end

   assign wr_accept    = wr.wr_valid && wr.wr_ready;
   assign lane_consume = {weight_en_0 | weight_en_1, {NUM_CH{fc_ivalid}}};

   for (genvar g = 0; g < NL; g++) begin : g_lane
      assign lane_push[g] = wr_accept && (wr.wr_lane == LANE_W'(g));

      bnn_lane_serialiser #(
         .WORD_W (WORD_W),
         .DEPTH  (DEPTH)
      ) u_lane (
         .clk       (clk),
         .rstn      (rstn),
         .flush     (flush),
         .push      (lane_push[g]),
         .push_data (wr.wr_data),
         .consume   (lane_consume[g]),
         .clr_err   (clr_err),
         .full      (lane_full[g]),
         .bit_out   (lane_bit[g]),
         .empty     (lane_empty[g]),
         .underrun  (underrun[g])
      );
   end

   assign fc_weight   = lane_bit[NUM_CH-1:0];
   assign conv_weight = lane_bit[NUM_CH];

`ifdef BNN_IMG_BIN_EN
   logic unused_pix_low;
   assign unused_pix_low = ^pix_data[6:0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         image_bit <= 1'b0;
      else if (pix_valid)
         image_bit <= ~pix_data[7];
   end
`endif
endmodule
